elevator_scan_controller: RTL and testbench



---
 rtl/elevator_scan_controller.sv | 188 ++++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller.sv
// -----------------------------------------------------------------------------
// elevator_scan_controller
//
// Multi-floor elevator controller with SCAN scheduling.
// - Floor requests are latched into a pending bitmap.
// - The car keeps its current direction while requests remain ahead of it,
//   then reverses.
// - Each served floor gets a timed door-open dwell.
//
// Optional feature macro: ELEV_ESTOP_EN
//   When defined, an extra input 'estop' freezes the state machine and the
//   shared counter while high. Requests are still latched during the freeze.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   estop         in   (ELEV_ESTOP_EN only) level-sensitive freeze
//   req_valid     in   single-cycle strobe, latches req_floor into pending
//   req_floor     in   requested floor [FLOOR_W]
//   current_floor out  registered car position [FLOOR_W]
//   pending       out  registered request bitmap [NUM_FLOORS]
//   moving        out  car is travelling (MOVE_UP or MOVE_DOWN)
//   dir_up        out  last/active travel direction, 1 = up
//   door_open     out  door dwell in progress
//   idle          out  in IDLE with nothing pending
//
// Handshake: req_valid has no ready. Every cycle with req_valid=1 is one
// request. It is accepted unconditionally, except in two cases where it is
// dropped:
//   - floor numbers >= NUM_FLOORS;
//   - a request for the current floor while the door is open, which extends
//     the dwell instead of being latched.
// -----------------------------------------------------------------------------
module elevator_scan_controller #(
   parameter int NUM_FLOORS   = 10,
   parameter int FLOOR_W      = 4,
   parameter int TICK_W       = 32,
   parameter int TRAVEL_TICKS = 10000000,
   parameter int DOOR_TICKS   = 20000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef ELEV_ESTOP_EN
   input  logic                  estop,
`endif
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  idle
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVE_UP   = 2'd1,
      ST_MOVE_DOWN = 2'd2,
      ST_DOOR_OPEN = 2'd3
   } state_t;

   localparam logic [TICK_W-1:0] TRAVEL_LAST = TICK_W'(TRAVEL_TICKS - 1);
   localparam logic [TICK_W-1:0] DOOR_LAST   = TICK_W'(DOOR_TICKS - 1);

   // FSM state register; checkers can bind to this signal by name.
   state_t             state;
   logic [TICK_W-1:0]  count;

   // run=0 freezes state and counter. It is never 0 without the estop feature.
   logic run;
`ifdef ELEV_ESTOP_EN
   assign run = ~estop;
`else
   assign run = 1'b1;
`endif

   logic                  here;
   logic                  above;
   logic                  below;
   logic [NUM_FLOORS-1:0] set_mask;
   logic [NUM_FLOORS-1:0] cur_mask;
   logic [NUM_FLOORS-1:0] set_eff;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic [NUM_FLOORS-1:0] pending_next;
   logic                  door_hit;

   // Scan the registered bitmap against the car position. The request decode
   // compares against each legal floor number, so out-of-range floors never
   // match any bit.
   always_comb begin
      here     = 1'b0;
      above    = 1'b0;
      below    = 1'b0;
      set_mask = '0;
      cur_mask = '0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (pending[f]) begin
            if (FLOOR_W'(f) > current_floor) above = 1'b1;
            if (FLOOR_W'(f) < current_floor) below = 1'b1;
            if (FLOOR_W'(f) == current_floor) here = 1'b1;
         end
         if (req_valid && (req_floor == FLOOR_W'(f))) set_mask[f] = 1'b1;
         if (current_floor == FLOOR_W'(f)) cur_mask[f] = 1'b1;
      end
   end

   // A repeat request for the floor whose door is open restarts the dwell.
   // It is never latched, so the floor is not served a second time.
   assign door_hit = req_valid && (state == ST_DOOR_OPEN) &&
                     (req_floor == current_floor);
   assign set_eff  = (state == ST_DOOR_OPEN) ? (set_mask & ~cur_mask) : set_mask;
   assign clr_mask = ((state == ST_IDLE) && run && here) ? cur_mask : '0;
   // The clear is applied after the set, so the clear wins on the same bit.
   assign pending_next = (pending | set_eff) & ~clr_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         count         <= '0;
         current_floor <= '0;
         pending       <= '0;
         dir_up        <= 1'b1;
      end else begin
         pending <= pending_next;
         if (run) begin
            case (state)
               ST_IDLE: begin
                  count <= '0;
                  if (here) begin
                     state <= ST_DOOR_OPEN;
                  end else if (dir_up && above) begin
                     state <= ST_MOVE_UP;
                  end else if (!dir_up && below) begin
                     state <= ST_MOVE_DOWN;
                  end else if (above) begin
                     state  <= ST_MOVE_UP;
                     dir_up <= 1'b1;
                  end else if (below) begin
                     state  <= ST_MOVE_DOWN;
                     dir_up <= 1'b0;
                  end
               end
               ST_MOVE_UP: begin
                  // Returning to IDLE at every floor gives one decision cycle
                  // per floor, which is where a stop can be taken.
                  if (count == TRAVEL_LAST) begin
                     current_floor <= current_floor + FLOOR_W'(1);
                     count         <= '0;
                     state         <= ST_IDLE;
                  end else begin
                     count <= count + TICK_W'(1);
                  end
               end
               ST_MOVE_DOWN: begin
                  if (count == TRAVEL_LAST) begin
                     current_floor <= current_floor - FLOOR_W'(1);
                     count         <= '0;
                     state         <= ST_IDLE;
                  end else begin
                     count <= count + TICK_W'(1);
                  end
               end
               ST_DOOR_OPEN: begin
                  if (door_hit) begin
                     count <= '0;
                  end else if (count == DOOR_LAST) begin
                     count <= '0;
                     state <= ST_IDLE;
                  end else begin
                     count <= count + TICK_W'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  count <= '0;
               end
            endcase
         end
      end
   end

   // Status flags are decoded purely from registers.
   assign moving    = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
   assign door_open = (state == ST_DOOR_OPEN);
   assign idle      = (state == ST_IDLE) && (pending == '0);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_controller
//
// Bench for elevator_scan_controller.
// - Main instance: 8 floors, TRAVEL_TICKS=4, DOOR_TICKS=3.
// - Second instance: 6 floors, used to exercise out-of-range floor requests.
// - A vector table covers the plain single-request trip.
// - Hand-written sequences cover SCAN ordering, dwell extension, mid-run reset
//   and (with ELEV_ESTOP_EN) the freeze.
// -----------------------------------------------------------------------------
module tb_elevator_scan_controller;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst_n;
   logic       rst6_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic       req_valid;
   logic [2:0] req_floor;
   logic [2:0] current_floor;
   logic [7:0] pending;
   logic       moving;
   logic       dir_up;
   logic       door_open;
   logic       idle;
   logic       estop;

   logic       req6_valid;
   logic [2:0] req6_floor;
   logic [2:0] current_floor6;
   logic [5:0] pending6;
   logic       moving6;
   logic       dir_up6;
   logic       door_open6;
   logic       idle6;
   logic       estop6;

   elevator_scan_controller #(
      .NUM_FLOORS(8), .FLOOR_W(3), .TICK_W(8), .TRAVEL_TICKS(4), .DOOR_TICKS(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef ELEV_ESTOP_EN
      .estop(estop),
`endif
      .req_valid(req_valid),
      .req_floor(req_floor),
      .current_floor(current_floor),
      .pending(pending),
      .moving(moving),
      .dir_up(dir_up),
      .door_open(door_open),
      .idle(idle)
   );

   elevator_scan_controller #(
      .NUM_FLOORS(6), .FLOOR_W(3), .TICK_W(8), .TRAVEL_TICKS(4), .DOOR_TICKS(3)
   ) dut6 (
      .clk(clk),
      .rst_n(rst6_n),
`ifdef ELEV_ESTOP_EN
      .estop(estop6),
`endif
      .req_valid(req6_valid),
      .req_floor(req6_floor),
      .current_floor(current_floor6),
      .pending(pending6),
      .moving(moving6),
      .dir_up(dir_up6),
      .door_open(door_open6),
      .idle(idle6)
   );

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];

   typedef struct {
      logic       v;
      logic [2:0] f;
      int         wait_n;
      logic [2:0] cf;
      logic [7:0] pend;
      logic       mv;
      logic       dir;
      logic       door;
      logic       idl;
   } vec_t;

   vec_t vecs[10];

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [2:0] f);
      req_valid = 1'b1;
      req_floor = f;
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] snap();
      return {17'd0, current_floor, pending, moving, dir_up, door_open, idle};
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int door_cycles;
      logic door_prev;
      logic pend_leak;

      rst_n      = 1'b0;
      rst6_n     = 1'b0;
      req_valid  = 1'b0;
      req_floor  = 3'd0;
      req6_valid = 1'b0;
      req6_floor = 3'd0;
      estop      = 1'b0;
      estop6     = 1'b0;

      // Trip 0 -> 3. Each row: drive one cycle of stimulus, wait wait_n edges
      // in total, then compare {floor, pending, moving, dir_up, door, idle}.
      vecs[0] = '{1'b1, 3'd3, 1, 3'd0, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 3'd0, 1, 3'd0, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 3'd0, 3, 3'd0, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 3'd0, 1, 3'd1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 3'd0, 1, 3'd1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 3'd0, 4, 3'd2, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 3'd0, 5, 3'd3, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 3'd0, 1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 3'd0, 2, 3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 3'd0, 1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

      // ---- reset state ----
      step();
      step();
      check("reset_held", snap(), {17'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
      rst_n  = 1'b1;
      rst6_n = 1'b1;
      step();
      check("reset_released", snap(), {17'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});

      // ---- table: single trip 0 -> 3 ----
      for (int i = 0; i < 10; i++) begin
         req_valid = vecs[i].v;
         req_floor = vecs[i].f;
         step();
         req_valid = 1'b0;
         for (int k = 1; k < vecs[i].wait_n; k++) step();
         check($sformatf("trip_vec%0d", i), snap(),
               {17'd0, vecs[i].cf, vecs[i].pend, vecs[i].mv, vecs[i].dir,
                vecs[i].door, vecs[i].idl});
      end

      // ---- move down one floor: 3 -> 2 reverses direction ----
      request(3'd2);
      for (int i = 0; i < 100 && !idle; i++) step();
      check("down_floor", {29'd0, current_floor}, 32'd2);
      check("down_dir", {31'd0, dir_up}, 32'd0);

      // ---- dwell extension at floor 2 ----
      request(3'd2);
      check("dwell_pending_seen", {24'd0, pending}, 32'h04);
      check("dwell_door_not_yet", {31'd0, door_open}, 32'd0);
      step();
      check("dwell_door_open", {31'd0, door_open}, 32'd1);
      check("dwell_pending_clear", {24'd0, pending}, 32'h00);
      door_cycles = 1;
      step();
      if (door_open) door_cycles++;
      request(3'd2);
      if (door_open) door_cycles++;
      pend_leak = (pending != 8'h00);
      for (int i = 0; i < 20 && door_open; i++) begin
         step();
         if (door_open) door_cycles++;
         if (pending != 8'h00) pend_leak = 1'b1;
      end
      check("dwell_cycles", door_cycles, 32'd5);
      check("dwell_rereq_not_latched", {31'd0, pend_leak}, 32'd0);
      check("dwell_then_idle", {31'd0, idle}, 32'd1);

      // ---- SCAN ordering: req 6, then at floor 2 req 4 and 1 ----
      do_reset();
      request(3'd6);
      for (int i = 0; i < 100 && current_floor != 3'd2; i++) step();
      check("scan_reach_2", {29'd0, current_floor}, 32'd2);
      request(3'd4);
      request(3'd1);
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd1);
      door_prev = door_open;
      for (int i = 0; i < 400 && !(exp_q.size() == 0 && idle); i++) begin
         step();
         if (door_open && !door_prev) begin
            if (exp_q.size() == 0) begin
               check("scan_extra_stop", {29'd0, current_floor}, 32'd7);
            end else begin
               check("scan_stop", {29'd0, current_floor}, {29'd0, exp_q.pop_front()});
            end
         end
         door_prev = door_open;
      end
      check("scan_all_stops", exp_q.size(), 32'd0);
      check("scan_final_dir", {31'd0, dir_up}, 32'd0);
      check("scan_final_floor", {29'd0, current_floor}, 32'd1);

      // ---- asynchronous reset in the middle of a trip ----
      request(3'd5);
      request(3'd7);
      for (int i = 0; i < 100 && current_floor != 3'd3; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrun_reset", snap(), {17'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
      step();
      rst_n = 1'b1;

      // ---- top floor on 8-floor car, then floor 0 while at floor 0 ----
      request(3'd7);
      check("req_top_floor", {24'd0, pending}, 32'h80);
      request(3'd0);
      check("req_floor0_latched", {24'd0, pending}, 32'h81);
      check("req_top_moving", {31'd0, moving}, 32'd1);

      // ---- out-of-range requests on the 6-floor car ----
      req6_valid = 1'b1;
      req6_floor = 3'd7;
      step();
      check("oor_7_ignored", {26'd0, pending6}, 32'h00);
      req6_floor = 3'd6;
      step();
      check("oor_6_ignored", {26'd0, pending6}, 32'h00);
      check("oor_still_idle", {31'd0, idle6}, 32'd1);
      req6_floor = 3'd5;
      step();
      req6_valid = 1'b0;
      check("inrange_5_latched", {26'd0, pending6}, 32'h20);

`ifdef ELEV_ESTOP_EN
      // ---- freeze mid-travel with the counter at 1 ----
      do_reset();
      request(3'd3);
      step();
      step();
      estop = 1'b1;
      request(3'd5);
      for (int i = 1; i < 10; i++) step();
      check("estop_floor_frozen", {29'd0, current_floor}, 32'd0);
      check("estop_moving_held", {31'd0, moving}, 32'd1);
      check("estop_req_latched", {24'd0, pending}, 32'h28);
      estop = 1'b0;
      step();
      step();
      check("estop_resume_early", {29'd0, current_floor}, 32'd0);
      step();
      check("estop_resume_step", {29'd0, current_floor}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
